rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
8-requester round-robin arbiter producing a registered one-hot grant vector. Sits directly upstream of the 8-to-3 encoder in the comb_ckts path. Its one-hot grant output drives the encoder's 8-bit input, which converts it to the 3-bit winner index. Guarantees the encoder only ever sees a one-hot or all-zero vector. Includes grant holding and a starvation limit.

Parameters:
MAX_HOLD, 4, max consecutive cycles one requester keeps the grant while others are waiting; 0 = unlimited (hold until release)

Ports:
clk      input   1  rising-edge clock
rst_n    input   1  asynchronous active-low reset
en       input   1  arbitration enable; 0 = no new grants issued
req      input   8  request vector, bit k = requester k
gnt      output  8  registered grant, one-hot or all-zero; feeds encoder input
gnt_vld  output  1  registered; 1 whenever gnt != 0

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-grant):
  - gnt=8'h00, gnt_vld=0.
  - Internal last-winner pointer ptr=3'd7, so requester 0 has top priority on the first arbitration after reset.
  - hold_cnt=0.
  - Release is synchronous to clk; the first arbitration happens on the first rising edge with rst_n high.
- Invariant: gnt is always one-hot or zero. gnt_vld == |gnt every cycle.
- Holder h: the set bit of gnt, if any.
- Per rising edge, in priority order:
  1. Holder h exists, req[h]=1, and no forced release → keep gnt, hold_cnt = hold_cnt+1, saturating at MAX_HOLD.
  2. Forced release: MAX_HOLD!=0, hold_cnt == MAX_HOLD-1, and any req[k]=1 with k!=h.
     - Rearbitrate immediately. The search starts at h+1, so h loses to any other requester.
  3. Holder drops req[h], or no holder exists → rearbitrate.
- Rearbitrate:
  - If en=0: gnt becomes 0.
  - If en=1: search indices ptr+1, ptr+2, ... mod 8; the first k with req[k]=1 wins.
  - On a win: gnt=1<<k, ptr=k, hold_cnt=0.
  - No requests → gnt=0; ptr unchanged.
- Wrap-around: the search index wraps 7→0. After ptr=7 the order is 0,1,...,7.
- Latency:
  - Request with arbiter idle at edge t → gnt valid after edge t (1-cycle registered latency).
  - Holder drops req before edge t → new winner (or zero) after edge t. No dead cycle between grants.
- Holder whose req is still high after a forced release may win again only once no other requester is pending.
- en=0 does not revoke an existing grant. The holder keeps it, subject to MAX_HOLD, until its req drops.
- A new grant is always to a currently-asserted req bit. Grant never goes to an idle requester.
- Single requester continuously asserted with MAX_HOLD>0 and no others: grant held indefinitely. Forced release requires a competitor.

Test Plan:
1. Reset, then req=8'h01 held → gnt=8'h01, gnt_vld=1 one cycle after first edge. Assert rst_n=0 mid-grant → gnt=8'h00 immediately, without a clock edge.
2. After reset req=8'hFF, each holder drops req one cycle after being granted → gnt sequence 01,02,04,08,10,20,40,80, then wraps to 01 if re-requested.
3. MAX_HOLD=4, req=8'h05 constant → gnt 01 for 4 cycles, then 04 for 4 cycles, then 01, alternating.
4. Holder 7 (gnt=8'h80) releases while req=8'h42 → next gnt=8'h02 (wrap to index 1 before 6).
5. en=0 while holder 3 active and req=8'h18 → gnt stays 08 until MAX_HOLD expiry/release, then gnt=00. Raise en → gnt=10 next edge.
6. Random req/en for 10k cycles with scoreboard → gnt always one-hot or zero, gnt_vld==|gnt, no requester waits more than 7*MAX_HOLD+7 cycles.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with grant holding and a starvation limit.
// Produces a registered one-hot (or zero) grant vector for a downstream 8-to-3 encoder.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_vld
);

  localparam int unsigned      CNT_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit               LIMITED   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [7:0]       gnt_q, gnt_d;
  logic             gnt_vld_q;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic       holder_live;
  logic       competitor;
  logic       forced;
  logic       keep;
  logic       win_found;
  logic [2:0] win_idx;

  assign holder_live = |(gnt_q & req);
  assign competitor  = |(req & ~gnt_q);

  // A saturated counter (lone holder for a long time) still counts as expired once a competitor shows up.
  assign forced = LIMITED && holder_live && competitor && (hold_cnt_q >= HOLD_LAST);
  assign keep   = holder_live && !forced;

  // Search ptr+1, ptr+2, ... wrapping 7->0; the last winner is visited last.
  always_comb begin
    logic [2:0] idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (keep) begin
      if (LIMITED && (hold_cnt_q != HOLD_SAT)) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end else begin
      hold_cnt_d = '0;
      if (en && win_found) begin
        gnt_d = 8'b1 << win_idx;
        ptr_d = win_idx;
      end else begin
        gnt_d = 8'h00;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= 8'h00;
      gnt_vld_q  <= 1'b0;
      ptr_q      <= 3'd7;
      hold_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      gnt_vld_q  <= |gnt_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;

  grant_shape_a: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q) && (gnt_vld_q == (|gnt_q)));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed spec sequences plus randomized traffic
// checked against a behavioural round-robin model; a monitor pops expectations each cycle.
module tb_rr_arbiter_8;

  localparam int MH    = 4;
  localparam int BOUND = 7 * MH + 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_vld;

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  bit   starve_on = 1'b0;
  int   max_wait  = 0;

  // Behavioural model: holder index (-1 = none), cycles it has been visible, last winner.
  int m_holder;
  int m_age;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_age    = 0;
    m_ptr    = 7;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    bit found;
    int k;
    if (m_holder >= 0 && r[m_holder]) begin
      bit others = (r & ~(8'(1) << m_holder)) != 8'h00;
      if (!(MH > 0 && m_age >= MH && others)) begin
        m_age++;
        return;
      end
    end
    m_holder = -1;
    m_age    = 0;
    found    = 1'b0;
    if (e) begin
      for (int i = 1; i <= 8; i++) begin
        k = (m_ptr + i) % 8;
        if (!found && r[k]) begin
          found    = 1'b1;
          m_holder = k;
          m_ptr    = k;
          m_age    = 1;
        end
      end
    end
  endtask

  function automatic logic [7:0] model_gnt();
    return (m_holder < 0) ? 8'h00 : 8'(1) << m_holder;
  endfunction

  // Drive one cycle of inputs; expected grant after the next edge is a constant when given, else the model's.
  task automatic step(input logic [7:0] r, input logic e, input int exp = -1);
    exp_t item;
    @(negedge clk);
    req = r;
    en  = e;
    model_step(r, e);
    item.gnt = (exp < 0) ? model_gnt() : 8'(exp);
    item.id  = step_no++;
    exp_q.push_back(item);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    en    = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    int   wait_cnt[8];
    foreach (wait_cnt[k]) wait_cnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("gnt step %0d", e.id), gnt, e.gnt);
        check($sformatf("gnt_vld step %0d", e.id), gnt_vld, |e.gnt);
        check($sformatf("onehot step %0d", e.id), $onehot0(gnt), 1);
      end
      for (int k = 0; k < 8; k++) begin
        if (starve_on && req[k] && !gnt[k]) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
    end
  end

  initial begin : driver
    logic [7:0] r;
    logic       e;
    int         guard;

    rst_n = 1'b0;
    req   = 8'h00;
    en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt", gnt, 8'h00);
    check("reset gnt_vld", gnt_vld, 1'b0);

    // 1: first grant one cycle after release, then asynchronous reset mid-grant.
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 1'b1, 8'h01);
    step(8'h01, 1'b1, 8'h01);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset gnt", gnt, 8'h00);
    check("async reset gnt_vld", gnt_vld, 1'b0);
    model_reset();
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    // 2: every requester asking, each holder drops right after its grant.
    r = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      step(r, 1'b1, 1 << k);
      r[k] = 1'b0;
    end
    step(8'h7F, 1'b1, 8'h01);

    // 3: two constant requesters alternate every MAX_HOLD cycles.
    do_reset();
    for (int rep = 0; rep < 4; rep++) begin
      for (int c = 0; c < MH; c++) step(8'h05, 1'b1, (rep % 2 == 0) ? 8'h01 : 8'h04);
    end

    // 4: holder 7 releases; search wraps to index 1 ahead of 6.
    do_reset();
    step(8'h80, 1'b1, 8'h80);
    step(8'h42, 1'b1, 8'h02);

    // 5: en low keeps holder 3 until forced release, then nothing; en high grants 4.
    do_reset();
    step(8'h08, 1'b1, 8'h08);
    for (int c = 1; c < MH; c++) step(8'h18, 1'b0, 8'h08);
    step(8'h18, 1'b0, 8'h00);
    step(8'h18, 1'b0, 8'h00);
    step(8'h18, 1'b1, 8'h10);

    // 6a: random requests and enable against the model.
    for (int n = 0; n < 4000; n++) begin
      r = 8'($urandom) & 8'($urandom);
      if (m_holder >= 0 && ($urandom % 4) != 0) r[m_holder] = 1'b1;
      e = ($urandom % 5) != 0;
      step(r, e);
    end

    // 6b: en held high, requesters stay up until served; starvation bound tracked.
    r = req;
    starve_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 8; k++) begin
        if (!r[k]) r[k] = ($urandom % 3) == 0;
        else if (m_holder == k && ($urandom % 3) == 0) r[k] = 1'b0;
      end
      step(r, 1'b1);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    starve_on = 1'b0;
    check("scoreboard drained", exp_q.size(), 0);
    check("starvation bound", (max_wait <= BOUND), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
